// File: rtl/division_operand_stager_pkg.sv
// Shared types for the division operand stager: the byte-pairing FSM states
// and the packed {dividend, divisor} operand pair handed to the divider.
package division_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic {
    ST_DIVIDEND = 1'b0,
    ST_DIVISOR  = 1'b1
  } stager_state_t;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] dividend;
    logic [DATA_W_DEFAULT-1:0] divisor;
  } div_pair_t;

endpackage

// File: rtl/division_operand_stager_fifo.sv
// First-word fall-through FIFO built from registers. The head entry is held
// in its own register so the read data leaves the block straight from a flop.
module sync_fifo_fwft #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push_s;
  logic             do_pop_s;

  // A push into a full FIFO or a pop from an empty one is ignored.
  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == {LVL_W{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = head_q;
  assign level     = level_q;

  // Next storage, pointers and occupancy; the head register tracks whatever
  // entry the read pointer will address after this cycle's push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    head_d = mem_d[rd_ptr_d];
  end

  // FIFO state registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      head_q   <= {WIDTH{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/division_operand_stager.sv
// Pairs a byte stream into {dividend, divisor} operands, drops pairs whose
// divisor is zero (with a pulse and a saturating count) and buffers the good
// pairs for the divider behind a small FWFT FIFO.
module division_operand_stager
  import division_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEFAULT,
  parameter  int DEPTH  = 4,
  parameter  int CNT_W  = 8,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sync,
  output logic [DATA_W-1:0] o_dividend,
  output logic [DATA_W-1:0] o_divisor,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_dbz,
  output logic [CNT_W-1:0]  o_dbz_count,
  output logic [LVL_W-1:0]  o_level
);

  stager_state_t       state_q, state_d;
  logic [DATA_W-1:0]   dividend_q, dividend_d;
  logic                dbz_q, dbz_d;
  logic [CNT_W-1:0]    dbz_cnt_q, dbz_cnt_d;
  logic                push_s;
  logic                accept_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [2*DATA_W-1:0] head_s;
  logic [2*DATA_W-1:0] pair_s;

  // Handshakes are decoded from registered FIFO occupancy only.
  assign o_ready     = !fifo_full_s;
  assign o_valid     = !fifo_empty_s;
  assign accept_s    = i_valid && o_ready;
  assign pair_s      = {dividend_q, i_data};
  assign o_dividend  = head_s[2*DATA_W-1:DATA_W];
  assign o_divisor   = head_s[DATA_W-1:0];
  assign o_dbz       = dbz_q;
  assign o_dbz_count = dbz_cnt_q;

  // Pairing FSM: realign wins over any byte, zero divisors are dropped.
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    dbz_d      = 1'b0;
    dbz_cnt_d  = dbz_cnt_q;
    push_s     = 1'b0;
    if (i_sync) begin
      state_d    = ST_DIVIDEND;
      dividend_d = {DATA_W{1'b0}};
    end else if (accept_s) begin
      case (state_q)
        ST_DIVIDEND: begin
          dividend_d = i_data;
          state_d    = ST_DIVISOR;
        end
        ST_DIVISOR: begin
          state_d = ST_DIVIDEND;
          if (i_data != {DATA_W{1'b0}}) begin
            push_s = 1'b1;
          end else begin
            dbz_d = 1'b1;
            if (dbz_cnt_q != {CNT_W{1'b1}}) begin
              dbz_cnt_d = dbz_cnt_q + CNT_W'(1);
            end else begin
              dbz_cnt_d = dbz_cnt_q;
            end
          end
        end
        default: begin
          state_d = ST_DIVIDEND;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM, pending dividend and divide-by-zero reporting registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_DIVIDEND;
      dividend_q <= {DATA_W{1'b0}};
      dbz_q      <= 1'b0;
      dbz_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      dbz_q      <= dbz_d;
      dbz_cnt_q  <= dbz_cnt_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_pair_fifo (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .push      (push_s),
    .push_data (pair_s),
    .pop       (i_ready),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (o_level)
  );

endmodule

// File: tb/tb_division_operand_stager.sv
// Bench for division_operand_stager: a queue-based model of the operand
// stream checked every cycle, plus hand-computed expectations at key points.
module tb_division_operand_stager;
  import division_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] i_data = 8'h00;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic              i_sync = 1'b0;
  logic [DATA_W-1:0] o_dividend;
  logic [DATA_W-1:0] o_divisor;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic              o_dbz;
  logic [CNT_W-1:0]  o_dbz_count;
  logic [LVL_W-1:0]  o_level;

  int n_checks = 0;
  int n_fail   = 0;

  // hand-computed expectation mailbox (-1 = field not checked)
  int lit_seq  = 0;
  int lit_seen = 0;
  int lit_div, lit_dvs, lit_lvl, lit_rdy, lit_cnt, lit_dbz;

  logic toggle_mode = 1'b0;

  division_operand_stager #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sync      (i_sync),
    .o_dividend  (o_dividend),
    .o_divisor   (o_divisor),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_dbz       (o_dbz),
    .o_dbz_count (o_dbz_count),
    .o_level     (o_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pairs, a pending-dividend flag, a counter.
  div_pair_t   mq[$];
  logic [7:0]  m_pend;
  bit          m_have;
  int          m_cnt;
  bit          m_dbz;
  bit          m_head_rst;

  initial begin
    bit m_pop, m_acc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        m_have = 0;
        m_pend = 8'h00;
        m_cnt = 0;
        m_dbz = 0;
        m_head_rst = 1;
      end
      chk("ready", o_ready, (mq.size() < DEPTH) ? 1 : 0);
      chk("valid", o_valid, (mq.size() > 0) ? 1 : 0);
      chk("level", o_level, mq.size());
      chk("dbz", o_dbz, m_dbz);
      chk("dbz_count", o_dbz_count, m_cnt);
      if (mq.size() > 0) begin
        chk("dividend", o_dividend, mq[0].dividend);
        chk("divisor", o_divisor, mq[0].divisor);
      end else if (m_head_rst) begin
        chk("dividend_rst", o_dividend, 0);
        chk("divisor_rst", o_divisor, 0);
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        if (lit_div >= 0) begin
          chk("lit_valid", o_valid, 1);
          chk("lit_dividend", o_dividend, lit_div);
          chk("lit_divisor", o_divisor, lit_dvs);
        end
        if (lit_lvl >= 0) chk("lit_level", o_level, lit_lvl);
        if (lit_rdy >= 0) chk("lit_ready", o_ready, lit_rdy);
        if (lit_cnt >= 0) chk("lit_dbz_count", o_dbz_count, lit_cnt);
        if (lit_dbz >= 0) chk("lit_dbz", o_dbz, lit_dbz);
      end
      if (rst_n) begin
        m_pop = (mq.size() > 0) && i_ready;
        m_acc = i_valid && (mq.size() < DEPTH);
        m_dbz = 0;
        if (m_pop) void'(mq.pop_front());
        if (i_sync) begin
          m_have = 0;
        end else if (m_acc) begin
          if (!m_have) begin
            m_pend = i_data;
            m_have = 1;
          end else begin
            m_have = 0;
            if (i_data != 8'h00) begin
              mq.push_back('{dividend: m_pend, divisor: i_data});
              m_head_rst = 0;
            end else begin
              m_dbz = 1;
              if (m_cnt < CNT_MAX) m_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input int div, input int dvs, input int lvl,
                     input int rdy, input int cnt, input int dbz);
    lit_div = div;
    lit_dvs = dvs;
    lit_lvl = lvl;
    lit_rdy = rdy;
    lit_cnt = cnt;
    lit_dbz = dbz;
    lit_seq++;
  endtask

  // Holds the byte until the stager takes it; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int   budget;
    logic acc;
    budget  = 300;
    acc     = 1'b0;
    i_valid = 1'b1;
    i_data  = b;
    while (!acc) begin
      if (budget == 0) begin
        $display("FAIL send_timeout: byte 0x%0h never accepted, o_ready=%0b", b, o_ready);
        $fatal(1, "byte handshake stalled");
      end
      acc = o_ready;
      @(posedge clk);
      #1;
      if (toggle_mode) i_ready = ~i_ready;
      budget--;
    end
    i_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    send_byte(a);
    send_byte(b);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b0;
    lit(-1, -1, 0, 1, 0, 0);
    tick(1);
    rst_n = 1'b1;
    i_ready = 1'b1;
    tick(1);

    // basic pair, latency one cycle after divisor acceptance
    send_pair(8'h64, 8'h05);
    lit(8'h64, 8'h05, 1, 1, -1, -1);
    tick(1);
    lit(-1, -1, 0, 1, -1, -1);
    tick(2);

    // zero divisor is dropped with one pulse
    send_pair(8'h10, 8'h00);
    lit(-1, -1, 0, 1, 1, 1);
    tick(1);
    lit(-1, -1, 0, 1, 1, 0);
    send_pair(8'h20, 8'h04);
    lit(8'h20, 8'h04, 1, 1, 1, 0);
    tick(3);

    // fill to full, 5th dividend held at the input
    i_ready = 1'b0;
    send_pair(8'hA1, 8'h01);
    send_pair(8'hA2, 8'h02);
    send_pair(8'hA3, 8'h03);
    send_pair(8'hA4, 8'h04);
    i_valid = 1'b1;
    i_data  = 8'hA5;
    tick(1);
    lit(8'hA1, 8'h01, 4, 0, -1, -1);
    tick(2);
    lit(8'hA1, 8'h01, 4, 0, -1, -1);
    tick(1);
    i_ready = 1'b1;
    send_pair(8'hA5, 8'h05);
    tick(8);
    lit(-1, -1, 0, 1, 1, 0);
    tick(1);

    // realign discards the half pair; byte under sync is ignored
    send_byte(8'h33);
    i_sync  = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h00;
    tick(1);
    i_sync  = 1'b0;
    i_valid = 1'b0;
    send_pair(8'h08, 8'h02);
    lit(8'h08, 8'h02, 1, 1, 1, 0);
    tick(3);

    // continuous stream with toggling divider ready
    toggle_mode = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send_pair(8'(i * 3 + 1), 8'((i % 7) + 1));
    end
    toggle_mode = 1'b0;
    i_ready = 1'b1;
    tick(10);
    lit(-1, -1, 0, 1, 1, 0);
    tick(1);

    // reset mid-pair with two pairs stored
    i_ready = 1'b0;
    send_pair(8'h41, 8'h11);
    send_pair(8'h42, 8'h12);
    send_byte(8'h7F);
    lit(8'h41, 8'h11, 2, 1, 1, -1);
    tick(1);
    rst_n = 1'b0;
    lit(-1, -1, 0, 1, 0, 0);
    tick(2);
    rst_n = 1'b1;
    i_ready = 1'b1;
    tick(1);
    send_pair(8'h09, 8'h03);
    lit(8'h09, 8'h03, 1, 1, 0, 0);
    tick(3);

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      send_pair(8'h01, 8'h00);
    end
    lit(-1, -1, 0, 1, 255, 1);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/division_operand_stager.md
Name: division_operand_stager

Overview:
- Upstream feeder for the fixed-point unsigned long divider.
- Takes a byte stream on a valid/ready interface and pairs consecutive bytes into {dividend, divisor}.
- Rejects divide-by-zero pairs and buffers complete pairs in a small FIFO.
- Presents buffered pairs to the divider on a valid/ready interface, so the divider sees only well-formed, aligned operand pairs.

Parameters:
- DATA_W, 8: operand width in bits, equal to the divider data width.
- DEPTH, 4: pair FIFO depth in entries; power of 2, minimum 2.
- CNT_W, 8: width of the saturating divide-by-zero counter.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_data  in  DATA_W  input byte stream.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  stager accepts the byte this cycle.
- i_sync  in  1  synchronous realign: discards any half-received pair.
- o_dividend  out  DATA_W  head-of-FIFO dividend.
- o_divisor  out  DATA_W  head-of-FIFO divisor; never 0.
- o_valid  out  1  head pair is valid.
- i_ready  in  1  divider accepts the head pair.
- o_dbz  out  1  one-cycle pulse when a zero-divisor pair is dropped.
- o_dbz_count  out  CNT_W  saturating count of dropped pairs.
- o_level  out  $clog2(DEPTH)+1  number of pairs currently stored.

Behaviour:
- Reset (asynchronous, i_reset_n=0):
  - FSM goes to ST_DIVIDEND; FIFO is emptied.
  - o_valid=0, o_dividend=0, o_divisor=0, o_dbz=0, o_dbz_count=0, o_level=0.
  - o_ready=1 once reset is released. A reset mid-pair discards the latched dividend.
- Byte accept: a byte is accepted when i_valid && o_ready; o_ready = !fifo_full.
- FSM, ST_DIVIDEND: on accept, latch the byte as the pending dividend and go to ST_DIVISOR.
- FSM, ST_DIVISOR, on accept:
  - If the byte is non-zero: push {pending dividend, byte} and go to ST_DIVIDEND.
  - If the byte is 0: push nothing, pulse o_dbz for exactly one cycle, increment o_dbz_count (saturating at 2^CNT_W-1), and go to ST_DIVIDEND.
- i_sync=1:
  - Forces ST_DIVIDEND next cycle and discards the pending dividend.
  - Any byte accepted in the same cycle is ignored, with no push and no dbz.
  - i_sync does not affect FIFO contents or the counter.
- FIFO is first-word fall-through from registers:
  - o_valid = !fifo_empty.
  - The head pair is stable while o_valid && !i_ready.
  - Pop occurs when o_valid && i_ready.
- Latency: a pushed pair appears at o_* one cycle after the divisor byte is accepted, when the FIFO was empty.
- Simultaneous push and pop: o_level is unchanged and order is preserved. When the FIFO is empty, the pushed pair becomes head next cycle; there is no same-cycle bypass.
- Full: o_ready=0, so no byte is accepted in either FSM state and the pending dividend is held. A pop while full raises o_ready in the next cycle, not combinationally.
- Empty: o_valid=0; i_ready is ignored.
- Pointers wrap modulo DEPTH. o_level is exact, 0..DEPTH.
- All outputs are registered except o_valid and o_ready, which are decoded from registered state.

Decomposition:
- Package division_pkg holds:
  - DATA_W default constant;
  - typedef enum logic {ST_DIVIDEND, ST_DIVISOR} stager_state_t;
  - typedef struct packed {logic [DATA_W-1:0] dividend; logic [DATA_W-1:0] divisor;} div_pair_t.
- One sub-module, sync_fifo_fwft, parameterised on width and depth, with push, pop, full, empty and level. The FSM and dbz logic stay in the top module.

Test Plan:
- Reset release, then bytes 0x64, 0x05 with i_ready=1 -> one cycle after 0x05 is accepted, o_valid=1 with o_dividend=0x64 and o_divisor=0x05; o_level=1, then 0 after the pop.
- Bytes 0x10, 0x00, 0x20, 0x04 -> o_dbz pulses once, for one cycle, after 0x00; o_dbz_count=1; only pair {0x20,0x04} is output.
- i_ready=0 while 5 pairs are sent with DEPTH=4 -> o_level reaches 4 and o_ready=0, and the 5th dividend is held. Raising i_ready drains the pairs in order, and the 5th pair then completes correctly.
- Send 0x33, assert i_sync for one cycle, then send 0x08, 0x02 -> the output is {0x08,0x02} only; 0x33 is discarded.
- Continuous stream with i_ready toggling every cycle over 64 pairs -> no loss, no duplicates, order preserved. The scoreboard matches every pair against a reference queue across pointer wrap.
- Assert i_reset_n=0 mid-pair, after 0x7F is accepted and the FIFO holds 2 pairs -> outputs clear immediately. After release, bytes 0x09, 0x03 yield {0x09,0x03} as the first output. Saturation check: 300 zero-divisor pairs -> o_dbz_count=255.
